// File: rtl/seven_seg_pkg.sv
// Shared constants for the seven-segment display path: active-high gfedcba
// patterns for each hex digit, the blank pattern and the segment bit positions.
package seven_seg_pkg;

    typedef logic [6:0] seg_t;

    // Segment bit positions within a pattern word (bit0 = a ... bit6 = g)
    localparam int unsigned SEG_A = 0;
    localparam int unsigned SEG_B = 1;
    localparam int unsigned SEG_C = 2;
    localparam int unsigned SEG_D = 3;
    localparam int unsigned SEG_E = 4;
    localparam int unsigned SEG_F = 5;
    localparam int unsigned SEG_G = 6;

    localparam seg_t SEG_BLANK = 7'h00;

    // Active-high patterns; b and d are lowercase so they differ from 8 and 0
    localparam seg_t SEG_0 = 7'h3F;
    localparam seg_t SEG_1 = 7'h06;
    localparam seg_t SEG_2 = 7'h5B;
    localparam seg_t SEG_3 = 7'h4F;
    localparam seg_t SEG_4 = 7'h66;
    localparam seg_t SEG_5 = 7'h6D;
    localparam seg_t SEG_6 = 7'h7D;
    localparam seg_t SEG_7 = 7'h07;
    localparam seg_t SEG_8 = 7'h7F;
    localparam seg_t SEG_9 = 7'h6F;
    localparam seg_t SEG_HEX_A = 7'h77;
    localparam seg_t SEG_HEX_B = 7'h7C;
    localparam seg_t SEG_HEX_C = 7'h39;
    localparam seg_t SEG_HEX_D = 7'h5E;
    localparam seg_t SEG_HEX_E = 7'h79;
    localparam seg_t SEG_HEX_F = 7'h71;

endpackage : seven_seg_pkg

// File: rtl/seven_seg_decoder_if.sv
// Nibble-to-pattern bus between a digit source and a segment decoder.
// master drives the nibble and reads the pattern; slave decodes it.
interface seven_seg_decoder_if;
    import seven_seg_pkg::*;

    logic [3:0] nibble;
    seg_t       seg;

    modport master (output nibble, input  seg);
    modport slave  (input  nibble, output seg);

endinterface : seven_seg_decoder_if

// File: rtl/seven_seg_lut.sv
// Purely combinational hex-digit lookup: nibble in, active-high gfedcba out.
// Usable on its own by any unregistered display path.
module seven_seg_lut
    import seven_seg_pkg::*;
(
    seven_seg_decoder_if.slave bus
);

    always_comb begin
        // NOTE: give every always_comb output a default first so no path can infer a latch.
        bus.seg = SEG_BLANK;
        unique case (bus.nibble)
            4'h0: bus.seg = SEG_0;
            4'h1: bus.seg = SEG_1;
            4'h2: bus.seg = SEG_2;
            4'h3: bus.seg = SEG_3;
            4'h4: bus.seg = SEG_4;
            4'h5: bus.seg = SEG_5;
            4'h6: bus.seg = SEG_6;
            4'h7: bus.seg = SEG_7;
            4'h8: bus.seg = SEG_8;
            4'h9: bus.seg = SEG_9;
            4'hA: bus.seg = SEG_HEX_A;
            4'hB: bus.seg = SEG_HEX_B;
            4'hC: bus.seg = SEG_HEX_C;
            4'hD: bus.seg = SEG_HEX_D;
            4'hE: bus.seg = SEG_HEX_E;
            4'hF: bus.seg = SEG_HEX_F;
        endcase
    end

endmodule : seven_seg_lut

// File: rtl/seven_seg_decoder.sv
// Registered hex-to-seven-segment decoder with selectable output polarity.
// Optional synchronous blanking input Blank when SEVEN_SEG_BLANK_EN is defined.
module seven_seg_decoder
    import seven_seg_pkg::*;
#(
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic       Clock,
    input  logic       Reset_n,
    input  logic [3:0] Reg1,
`ifdef SEVEN_SEG_BLANK_EN
    input  logic       Blank,
`endif
    output logic [6:0] HEX0
);

    // XOR mask turning an active-high pattern into the board's drive polarity
    localparam seg_t POL_MASK = ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam seg_t BLANK_DRIVE = SEG_BLANK ^ POL_MASK;

    seven_seg_decoder_if w_lut_bus ();

    seg_t w_pattern;
    seg_t r_hex;

    assign w_lut_bus.nibble = Reg1;

    seven_seg_lut u_lut (
        .bus (w_lut_bus)
    );

`ifdef SEVEN_SEG_BLANK_EN
    assign w_pattern = Blank ? SEG_BLANK : w_lut_bus.seg;
`else
    assign w_pattern = w_lut_bus.seg;
`endif

    always_ff @(posedge Clock or negedge Reset_n) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!Reset_n) begin
            r_hex <= BLANK_DRIVE;
        end else begin
            r_hex <= w_pattern ^ POL_MASK;
        end
    end

    assign HEX0 = r_hex;

endmodule : seven_seg_decoder

// File: tb/tb_seven_seg_decoder.sv
// Self-checking bench for seven_seg_decoder: both polarities, full digit sweep,
// reset, latency/hold and (with SEVEN_SEG_BLANK_EN) blanking.
module tb_seven_seg_decoder;

    typedef struct {
        logic [3:0] nibble;
        logic [6:0] exp_al;
        logic [6:0] exp_ah;
    } vec_t;

    logic       clk;
    logic       rst_n;
    logic [6:0] hex_ah;
`ifdef SEVEN_SEG_BLANK_EN
    logic       blank;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    seven_seg_decoder_if bus ();

    seven_seg_decoder #(.ACTIVE_LOW(1'b1)) dut_al (
        .Clock   (clk),
        .Reset_n (rst_n),
        .Reg1    (bus.nibble),
`ifdef SEVEN_SEG_BLANK_EN
        .Blank   (blank),
`endif
        .HEX0    (bus.seg)
    );

    seven_seg_decoder #(.ACTIVE_LOW(1'b0)) dut_ah (
        .Clock   (clk),
        .Reset_n (rst_n),
        .Reg1    (bus.nibble),
`ifdef SEVEN_SEG_BLANK_EN
        .Blank   (blank),
`endif
        .HEX0    (hex_ah)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [6:0] actual, input logic [6:0] expected);
        n_checks++;
        if (actual === expected) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 7'h%02h, expected 7'h%02h", name, actual, expected);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    vec_t vecs[16];

    initial begin
        vecs[0]  = '{4'h0, 7'h40, 7'h3F};
        vecs[1]  = '{4'h1, 7'h79, 7'h06};
        vecs[2]  = '{4'h2, 7'h24, 7'h5B};
        vecs[3]  = '{4'h3, 7'h30, 7'h4F};
        vecs[4]  = '{4'h4, 7'h19, 7'h66};
        vecs[5]  = '{4'h5, 7'h12, 7'h6D};
        vecs[6]  = '{4'h6, 7'h02, 7'h7D};
        vecs[7]  = '{4'h7, 7'h78, 7'h07};
        vecs[8]  = '{4'h8, 7'h00, 7'h7F};
        vecs[9]  = '{4'h9, 7'h10, 7'h6F};
        vecs[10] = '{4'hA, 7'h08, 7'h77};
        vecs[11] = '{4'hB, 7'h03, 7'h7C};
        vecs[12] = '{4'hC, 7'h46, 7'h39};
        vecs[13] = '{4'hD, 7'h21, 7'h5E};
        vecs[14] = '{4'hE, 7'h06, 7'h79};
        vecs[15] = '{4'hF, 7'h0E, 7'h71};

        rst_n      = 1'b0;
        bus.nibble = 4'h5;
`ifdef SEVEN_SEG_BLANK_EN
        blank      = 1'b0;
`endif
        tick();
        check("reset_al", bus.seg, 7'h7F);
        check("reset_ah", hex_ah, 7'h00);

        // First edge after release loads the decoded nibble directly
        rst_n = 1'b1;
        tick();
        check("release_al", bus.seg, 7'h12);
        check("release_ah", hex_ah, 7'h6D);

        // Mid-cycle async reset must blank without any clock edge
        bus.nibble = 4'h8;
        #1;
        rst_n = 1'b0;
        #1;
        check("async_reset_al", bus.seg, 7'h7F);
        check("async_reset_ah", hex_ah, 7'h00);
        rst_n = 1'b1;
        tick();
        check("post_reset_8_al", bus.seg, 7'h00);
        check("post_reset_8_ah", hex_ah, 7'h7F);

        // Back-to-back sweep: a new nibble each cycle, one-cycle latency
        for (int i = 0; i < 16; i++) begin
            bus.nibble = vecs[i].nibble;
            tick();
            check($sformatf("sweep_al_%h", vecs[i].nibble), bus.seg, vecs[i].exp_al);
            check($sformatf("sweep_ah_%h", vecs[i].nibble), hex_ah, vecs[i].exp_ah);
        end

        // Output holds between edges even when Reg1 changes
        bus.nibble = 4'h3;
        tick();
        check("hold_n_al", bus.seg, 7'h30);
        bus.nibble = 4'hA;
        #2;
        check("hold_between_al", bus.seg, 7'h30);
        check("hold_between_ah", hex_ah, 7'h4F);
        tick();
        check("hold_n1_al", bus.seg, 7'h08);
        check("hold_n1_ah", hex_ah, 7'h77);

`ifdef SEVEN_SEG_BLANK_EN
        bus.nibble = 4'h1;
        blank      = 1'b1;
        tick();
        check("blank_on_al", bus.seg, 7'h7F);
        check("blank_on_ah", hex_ah, 7'h00);
        blank = 1'b0;
        #2;
        check("blank_hold_al", bus.seg, 7'h7F);
        tick();
        check("blank_off_al", bus.seg, 7'h79);
        check("blank_off_ah", hex_ah, 7'h06);
        blank = 1'b1;
        tick();
        rst_n = 1'b0;
        #1;
        check("blank_reset_al", bus.seg, 7'h7F);
        rst_n = 1'b1;
        blank = 1'b0;
        tick();
        check("blank_release_al", bus.seg, 7'h79);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_seven_seg_decoder
